// File: rtl/z_calc_pkg.sv
// rtl/z_calc_pkg.sv - shared fixed-point constants and types for the Julia z-step pipeline
package z_calc_pkg;

    localparam int Z_WIDTH      = 22;
    localparam int Z_FRACTIONAL = 11;
    localparam int Z_INTEGRAL   = 11;

    localparam int ESCAPE_RADIUS_SQ = 4 << Z_FRACTIONAL;
    localparam int FXP_MAX          = (1 << (Z_WIDTH - 1)) - 1;
    localparam int FXP_MIN          = -(1 << (Z_WIDTH - 1));

    typedef logic signed [Z_WIDTH-1:0] fxp_t;

endpackage

// File: rtl/fxp_mult.sv
// rtl/fxp_mult.sv - combinational signed fixed-point multiply, product floored by FRACTIONAL bits
module fxp_mult
    import z_calc_pkg::*;
#(
    parameter int WIDTH      = Z_WIDTH,
    parameter int FRACTIONAL = Z_FRACTIONAL
) (
    input  logic signed [WIDTH-1:0]              a,
    input  logic signed [WIDTH-1:0]              b,
    output logic signed [2*WIDTH-FRACTIONAL-1:0] p
);
    localparam int FW = 2 * WIDTH;
    localparam int PW = 2 * WIDTH - FRACTIONAL;

    logic signed [FW-1:0] full;

    assign full = FW'(a) * FW'(b);
    // Arithmetic shift floors toward -inf; the dropped top bits are pure sign copies.
    assign p    = PW'(full >>> FRACTIONAL);

endmodule

// File: rtl/julia_z_calculator.sv
// rtl/julia_z_calculator.sv - 3-stage pipelined z^2+c step with |z|^2; optional escaped_out via Z_CALC_ESCAPE_EN
module julia_z_calculator
    import z_calc_pkg::*;
#(
    parameter int WIDTH      = Z_WIDTH,
    parameter int FRACTIONAL = Z_FRACTIONAL,
    parameter int INTEGRAL   = Z_INTEGRAL
) (
    input  logic                    clk,
    input  logic                    n_rst,
    input  logic                    valid_in,
    input  logic signed [WIDTH-1:0] z_real_in,
    input  logic signed [WIDTH-1:0] z_imag_in,
    input  logic signed [WIDTH-1:0] c_real_in,
    input  logic signed [WIDTH-1:0] c_imag_in,
    input  logic [7:0]              iteration_in,
`ifdef Z_CALC_ESCAPE_EN
    output logic                    escaped_out,
`endif
    output logic                    valid_out,
    output logic signed [WIDTH-1:0] z_real_out,
    output logic signed [WIDTH-1:0] z_imag_out,
    output logic signed [WIDTH-1:0] size_squared_out,
    output logic [7:0]              iteration_out
);
    localparam int PW = 2 * WIDTH - FRACTIONAL;
    localparam int EW = WIDTH + 2;
    localparam int SW = EW + 2;
    localparam int QW = PW + 1;

    localparam logic signed [PW-1:0] EXT_MAX  = {{(PW-EW+1){1'b0}}, {(EW-1){1'b1}}};
    localparam logic signed [PW-1:0] EXT_MIN  = {{(PW-EW+1){1'b1}}, {(EW-1){1'b0}}};
    localparam logic signed [SW-1:0] W_MAX    = {{(SW-WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
    localparam logic signed [SW-1:0] W_MIN    = {{(SW-WIDTH+1){1'b1}}, {(WIDTH-1){1'b0}}};
    localparam logic signed [QW-1:0] SIZE_MAX = {{(QW-WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};

    if (WIDTH != INTEGRAL + FRACTIONAL) begin : g_width_check
        $error("julia_z_calculator: WIDTH must equal INTEGRAL + FRACTIONAL");
    end
    if (WIDTH == Z_WIDTH && FRACTIONAL == Z_FRACTIONAL &&
        (FXP_MAX != (2 ** (WIDTH - 1)) - 1 || FXP_MIN != -(2 ** (WIDTH - 1)) ||
         ESCAPE_RADIUS_SQ != (4 << FRACTIONAL))) begin : g_pkg_check
        $error("julia_z_calculator: z_calc_pkg constants disagree with parameters");
    end

    function automatic logic signed [EW-1:0] clip_ext(input logic signed [PW-1:0] v);
        if (v > EXT_MAX) return EXT_MAX[EW-1:0];
        if (v < EXT_MIN) return EXT_MIN[EW-1:0];
        return v[EW-1:0];
    endfunction

    function automatic logic signed [WIDTH-1:0] clip_w(input logic signed [SW-1:0] v);
        if (v > W_MAX) return W_MAX[WIDTH-1:0];
        if (v < W_MIN) return W_MIN[WIDTH-1:0];
        return v[WIDTH-1:0];
    endfunction

    logic signed [PW-1:0]    rr_full, ii_full, ri_full;
    logic signed [EW-1:0]    s1_rr, s1_ii, s1_ri;
    logic signed [WIDTH-1:0] s1_cr, s1_ci;
    logic [7:0]              s1_iter;
    logic                    s1_valid;

    fxp_mult #(.WIDTH(WIDTH), .FRACTIONAL(FRACTIONAL)) u_mult_rr (.a(z_real_in), .b(z_real_in), .p(rr_full));
    fxp_mult #(.WIDTH(WIDTH), .FRACTIONAL(FRACTIONAL)) u_mult_ii (.a(z_imag_in), .b(z_imag_in), .p(ii_full));
    fxp_mult #(.WIDTH(WIDTH), .FRACTIONAL(FRACTIONAL)) u_mult_ri (.a(z_real_in), .b(z_imag_in), .p(ri_full));

    logic signed [SW-1:0]    re_wide, im_wide;
    logic signed [WIDTH-1:0] s2_re, s2_im;
    logic [7:0]              s2_iter;
    logic                    s2_valid;

    assign re_wide = SW'(s1_rr) - SW'(s1_ii) + SW'(s1_cr);
    assign im_wide = (SW'(s1_ri) <<< 1) + SW'(s1_ci);

    logic signed [PW-1:0]    re_sq, im_sq;
    logic signed [QW-1:0]    size_wide;
    logic signed [WIDTH-1:0] size_next;

    fxp_mult #(.WIDTH(WIDTH), .FRACTIONAL(FRACTIONAL)) u_mult_re (.a(s2_re), .b(s2_re), .p(re_sq));
    fxp_mult #(.WIDTH(WIDTH), .FRACTIONAL(FRACTIONAL)) u_mult_im (.a(s2_im), .b(s2_im), .p(im_sq));

    // Both squares are non-negative, so only the upper bound can be exceeded.
    assign size_wide = QW'(re_sq) + QW'(im_sq);
    assign size_next = (size_wide > SIZE_MAX) ? SIZE_MAX[WIDTH-1:0] : size_wide[WIDTH-1:0];

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            s1_rr            <= '0;
            s1_ii            <= '0;
            s1_ri            <= '0;
            s1_cr            <= '0;
            s1_ci            <= '0;
            s1_iter          <= '0;
            s1_valid         <= 1'b0;
            s2_re            <= '0;
            s2_im            <= '0;
            s2_iter          <= '0;
            s2_valid         <= 1'b0;
            z_real_out       <= '0;
            z_imag_out       <= '0;
            size_squared_out <= '0;
            iteration_out    <= '0;
            valid_out        <= 1'b0;
        end else begin
            s1_rr            <= clip_ext(rr_full);
            s1_ii            <= clip_ext(ii_full);
            s1_ri            <= clip_ext(ri_full);
            s1_cr            <= c_real_in;
            s1_ci            <= c_imag_in;
            s1_iter          <= iteration_in;
            s1_valid         <= valid_in;
            s2_re            <= clip_w(re_wide);
            s2_im            <= clip_w(im_wide);
            s2_iter          <= s1_iter;
            s2_valid         <= s1_valid;
            z_real_out       <= s2_re;
            z_imag_out       <= s2_im;
            size_squared_out <= size_next;
            iteration_out    <= s2_iter;
            valid_out        <= s2_valid;
        end
    end

`ifdef Z_CALC_ESCAPE_EN
    localparam logic signed [WIDTH-1:0] ESC_RADIUS = WIDTH'(4 << FRACTIONAL);

    logic s1_sat, s2_sat;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            s1_sat      <= 1'b0;
            s2_sat      <= 1'b0;
            escaped_out <= 1'b0;
        end else begin
            s1_sat      <= (rr_full > EXT_MAX) || (ii_full > EXT_MAX) ||
                           (ri_full > EXT_MAX) || (ri_full < EXT_MIN);
            s2_sat      <= s1_sat || (re_wide > W_MAX) || (re_wide < W_MIN) ||
                           (im_wide > W_MAX) || (im_wide < W_MIN);
            escaped_out <= s2_valid && ((size_next > ESC_RADIUS) || (size_wide > SIZE_MAX) || s2_sat);
        end
    end
`endif

endmodule

// File: tb/tb_julia_z_calculator.sv
// tb/tb_julia_z_calculator.sv - directed self-checking bench for julia_z_calculator
module tb_julia_z_calculator;
    import z_calc_pkg::*;

    logic       tb_clk = 1'b0;
    logic       n_rst;
    logic       valid_in;
    fxp_t       z_real_in, z_imag_in, c_real_in, c_imag_in;
    logic [7:0] iteration_in;
    logic       valid_out;
    fxp_t       z_real_out, z_imag_out, size_squared_out;
    logic [7:0] iteration_out;
`ifdef Z_CALC_ESCAPE_EN
    logic       escaped_out;
`endif

    int tests = 0;
    int fails = 0;

    always #5 tb_clk = ~tb_clk;

    julia_z_calculator dut (
        .clk              (tb_clk),
        .n_rst            (n_rst),
        .valid_in         (valid_in),
        .z_real_in        (z_real_in),
        .z_imag_in        (z_imag_in),
        .c_real_in        (c_real_in),
        .c_imag_in        (c_imag_in),
        .iteration_in     (iteration_in),
`ifdef Z_CALC_ESCAPE_EN
        .escaped_out      (escaped_out),
`endif
        .valid_out        (valid_out),
        .z_real_out       (z_real_out),
        .z_imag_out       (z_imag_out),
        .size_squared_out (size_squared_out),
        .iteration_out    (iteration_out)
    );

    task automatic check(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input longint zr, input longint zi,
                         input longint cr, input longint ci, input int it);
        valid_in     = v;
        z_real_in    = zr[21:0];
        z_imag_in    = zi[21:0];
        c_real_in    = cr[21:0];
        c_imag_in    = ci[21:0];
        iteration_in = it[7:0];
    endtask

    task automatic expect_out(input string tag, input longint ere, input longint eim,
                              input longint esz, input int it, input logic eesc);
        check({tag, ".valid"}, valid_out, 1);
        check({tag, ".re"}, z_real_out, ere);
        check({tag, ".im"}, z_imag_out, eim);
        check({tag, ".size"}, size_squared_out, esz);
        check({tag, ".iter"}, iteration_out, it);
`ifdef Z_CALC_ESCAPE_EN
        check({tag, ".escaped"}, escaped_out, eesc);
`else
        if (eesc === 1'bx) $display("[TB] note: %s has unknown escape expectation", tag);
`endif
    endtask

    task automatic expect_zero(input string tag);
        check({tag, ".valid"}, valid_out, 0);
        check({tag, ".re"}, z_real_out, 0);
        check({tag, ".im"}, z_imag_out, 0);
        check({tag, ".size"}, size_squared_out, 0);
        check({tag, ".iter"}, iteration_out, 0);
`ifdef Z_CALC_ESCAPE_EN
        check({tag, ".escaped"}, escaped_out, 0);
`endif
    endtask

    task automatic run_one(input string tag, input longint zr, input longint zi,
                           input longint cr, input longint ci, input int it,
                           input longint ere, input longint eim, input longint esz, input logic eesc);
        drive(1'b1, zr, zi, cr, ci, it);
        @(posedge tb_clk); #1 drive(1'b0, 0, 0, 0, 0, 0);
        @(posedge tb_clk); #1 check({tag, ".early_valid"}, valid_out, 0);
        @(posedge tb_clk); #1 expect_out(tag, ere, eim, esz, it, eesc);
        @(posedge tb_clk); #1 check({tag, ".valid_drop"}, valid_out, 0);
    endtask

    initial begin
        n_rst = 1'b0;
        drive(1'b0, 0, 0, 0, 0, 0);
        repeat (2) @(posedge tb_clk);
        #1 expect_zero("reset");
        n_rst = 1'b1;

        run_one("step1", 2048, 1024, -1024, 1024, 1, 512, 3072, 4736, 1'b0);
        run_one("feedback", 512, 3072, -1024, 1024, 1, -5504, 2560, 17992, 1'b1);

        drive(1'b1, 2048, 1024, -1024, 1024, 5);
        @(posedge tb_clk); #1 drive(1'b1, 512, 3072, -1024, 1024, 9);
        @(posedge tb_clk); #1 drive(1'b0, 0, 0, 0, 0, 0);
        @(posedge tb_clk); #1 expect_out("b2b_a", 512, 3072, 4736, 5, 1'b0);
        @(posedge tb_clk); #1 expect_out("b2b_b", -5504, 2560, 17992, 9, 1'b1);
        @(posedge tb_clk); #1 check("b2b.valid_drop", valid_out, 0);

        run_one("saturate", 2048000, 0, 0, 0, 7, 2097151, 0, 2097151, 1'b1);
        run_one("most_neg", -2097152, 0, 0, 0, 8, 2097151, 0, 2097151, 1'b1);
        run_one("zero", 0, 0, -1024, 0, 3, -1024, 0, 512, 1'b0);
        run_one("floor", 3, -1, 0, 0, 200, 0, -2, 0, 1'b0);
        run_one("all_zero", 0, 0, 0, 0, 0, 0, 0, 0, 1'b0);

        drive(1'b1, 2048, 1024, -1024, 1024, 42);
        repeat (3) @(posedge tb_clk);
        #1 check("midstream.valid_before_reset", valid_out, 1);
        n_rst = 1'b0;
        #1 expect_zero("midstream_reset");
        drive(1'b0, 0, 0, 0, 0, 0);
        @(posedge tb_clk); #1 n_rst = 1'b1;
        repeat (3) @(posedge tb_clk);
        #1 check("post_reset.flushed", valid_out, 0);
        run_one("post_reset", 512, 3072, -1024, 1024, 77, -5504, 2560, 17992, 1'b1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/julia_z_calculator.md
Name: julia_z_calculator

Overview:
- Computes one Julia/Mandelbrot iteration step in signed fixed point: z_out = z_in² + c, plus |z_out|².
- Fully pipelined, one new operand set accepted per clock, results after a fixed 3-cycle latency.
- Sits in the Julia worker's pixel loop: the caller feeds z_out back as z_in and compares size_squared_out against the escape radius.
- The iteration count passes through unchanged and stays aligned with its data.

Parameters:
- WIDTH, 22, total word width of every z/c/size operand.
- FRACTIONAL, 11, fractional bits; 1.0 is 2^FRACTIONAL, so 2048 at defaults.
- INTEGRAL, 11, integer bits including sign; WIDTH must equal INTEGRAL+FRACTIONAL, enforced by an elaboration-time check.

Ports:
- clk  input  1  rising-edge clock
- n_rst  input  1  asynchronous active-low reset
- valid_in  input  1  operands on this cycle are valid
- z_real_in  input  WIDTH  signed Re(z)
- z_imag_in  input  WIDTH  signed Im(z)
- c_real_in  input  WIDTH  signed Re(c)
- c_imag_in  input  WIDTH  signed Im(c)
- iteration_in  input  8  unsigned iteration tag
- valid_out  output  1  outputs valid
- z_real_out  output  WIDTH  signed Re(z²+c)
- z_imag_out  output  WIDTH  signed Im(z²+c)
- size_squared_out  output  WIDTH  signed, always ≥0: Re²+Im² of the z outputs
- iteration_out  output  8  iteration_in delayed to match

Behaviour:
- Reset: n_rst low clears all pipeline registers asynchronously. All outputs, including valid_out, read 0. Reset mid-stream discards in-flight data; the first valid_out follows 3 cycles after the first valid_in once reset is released.
- Latency and throughput: exactly 3 cycles from valid_in to valid_out, with all outputs aligned. No stall and no backpressure.
- Data registers always load. Only valid_out is meaningful as a qualifier.
- Stage 1:
  - rr = zr·zr, ii = zi·zi, ri = zr·zi.
  - Each product is a full 2·WIDTH-bit signed multiply, arithmetic-shifted right by FRACTIONAL (truncation toward −∞), kept at WIDTH+2 bits.
  - c, iteration and valid are registered alongside.
- Stage 2:
  - re = rr − ii + cr; im = 2·ri + ci.
  - Each is computed at extended width, then saturated to the signed WIDTH range [−2^(WIDTH−1), 2^(WIDTH−1)−1].
- Stage 3:
  - size = re·re + im·im, each product shifted by FRACTIONAL as above.
  - The sum saturates to 2^(WIDTH−1)−1; it is never negative.
  - re, im and iteration are registered through this stage unchanged.
- iteration_out is a pure delayed copy of iteration_in; there is no increment.
- Boundaries:
  - The most negative input squares to a positive result; it saturates, never wraps.
  - Zero inputs give exact zero.

Optional Feature:
- Macro Z_CALC_ESCAPE_EN.
- When defined: adds output escaped_out (1 bit), registered with stage 3. It is 1 when valid_out is 1 and size_squared_out > 4.0 (4<<FRACTIONAL) or any stage saturated. It resets to 0.
- When undefined: the port is absent and there is no extra logic.

Decomposition:
- Package z_calc_pkg holds:
  - default WIDTH/FRACTIONAL/INTEGRAL constants;
  - ESCAPE_RADIUS_SQ (4.0 in fixed point);
  - the saturation max/min constants;
  - typedef fxp_t (signed WIDTH).
- One sub-module, fxp_mult: signed WIDTH×WIDTH multiply with shift by FRACTIONAL, combinational. It is instantiated 5 times (3 in stage 1, 2 in stage 3).

Test Plan:
- Reset: assert n_rst=0 mid-stream -> all outputs 0 immediately; valid_out stays 0 until 3 cycles after the next valid_in.
- Step 1: z=2048+1024i (1+0.5i), c=−1024+1024i, iteration=1 -> after 3 cycles z_real_out=512 (0.25), z_imag_out=3072 (1.5), size_squared_out=4736 (2.3125), iteration_out=1.
- Feedback: z=512+3072i, same c, iteration=1 -> z_real_out=−5504 (−2.6875), z_imag_out=2560 (1.25), size_squared_out=17992 (8.78515625), iteration_out=1.
- Back-to-back: issue both cases above on consecutive cycles -> results appear on consecutive cycles in order, each with its own iteration tag.
- Saturation: z=2048000+0i (1000.0), c=0 -> z_real_out=2097151, z_imag_out=0, size_squared_out=2097151. With Z_CALC_ESCAPE_EN, escaped_out=1.
- Zero: z=0, c=−1024+0i -> z_real_out=−1024, z_imag_out=0, size_squared_out=512 (0.25). With Z_CALC_ESCAPE_EN, escaped_out=0.
